// File: rtl/conv3x3_phase_sched.sv
// Phase sequencer for the 4-lane conv3x3 wrapper: streams every 3x3 window once per phase,
// waits for the wrapper pipeline to drain, then advances the output-channel phase.
//
// state   | meaning
// S_IDLE  | waiting for iStart
// S_RUN   | accepting windows in raster order
// S_DRAIN | all windows sent, waiting for outstanding wrapper outputs
// S_MAPDN | one-cycle oMapDone, pick next phase or finish
// S_DONE  | one-cycle oDone, back to idle
module conv3x3_phase_sched #(
  parameter int IMG_W     = 28,
  parameter int IMG_H     = 28,
  parameter int NPHASE    = 4,
  parameter int DRAIN_MAX = 16
) (
  input  logic       iClk,
  input  logic       iRsn,
  input  logic       iStart,
  input  logic       iWinValid,
  output logic       oWinReady,
  output logic       oSrcRestart,
  output logic       oInValid,
  output logic       oMapDone,
  input  logic [3:0] iValid4,
  output logic [1:0] oPhase,
  output logic [7:0] oRow,
  output logic [7:0] oCol,
  output logic       oBusy,
  output logic       oDone,
  output logic       oErr
);

  localparam logic [7:0]  OW_LAST  = 8'(IMG_W - 3);
  localparam logic [7:0]  OH_LAST  = 8'(IMG_H - 3);
  localparam logic [15:0] NWIN     = 16'((IMG_W - 2) * (IMG_H - 2));
  localparam logic [1:0]  PH_LAST  = 2'(NPHASE - 1);
  localparam logic [7:0]  TMR_LOAD = 8'(DRAIN_MAX - 1);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_MAPDN, S_DONE} state_t;

  state_t      state_q;
  logic [7:0]  row_q, col_q, tmr_q;
  logic [1:0]  phase_q;
  logic [15:0] outcnt_q, outcnt_d;
  logic        win_ready_q, src_restart_q, map_done_q, done_q, err_q;

  logic fire, out_seen, counting, overflow, start_acc, err_now, drained;

  assign fire      = iWinValid & win_ready_q;
  assign out_seen  = |iValid4;
  assign counting  = state_q inside {S_RUN, S_DRAIN, S_MAPDN};
  assign overflow  = counting & out_seen & (outcnt_q == NWIN);
  assign outcnt_d  = (counting & out_seen & ~overflow) ? outcnt_q + 16'd1 : outcnt_q;
  assign start_acc = (state_q == S_IDLE) & iStart;
  assign err_now   = (out_seen & (iValid4 != 4'hF)) | ((state_q == S_IDLE) & out_seen) | overflow;
  // drain completion looks at the count including this cycle's output
  assign drained   = (outcnt_d == NWIN);

  always_ff @(posedge iClk or negedge iRsn) begin
    if (!iRsn) begin
      state_q       <= S_IDLE;
      row_q         <= '0;
      col_q         <= '0;
      phase_q       <= '0;
      outcnt_q      <= '0;
      tmr_q         <= '0;
      win_ready_q   <= 1'b0;
      src_restart_q <= 1'b0;
      map_done_q    <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      src_restart_q <= 1'b0;
      map_done_q    <= 1'b0;
      done_q        <= 1'b0;
      outcnt_q      <= outcnt_d;
      err_q         <= start_acc ? 1'b0 : (err_q | err_now);
      case (state_q)
        S_IDLE: begin
          if (iStart) begin
            state_q       <= S_RUN;
            phase_q       <= '0;
            row_q         <= '0;
            col_q         <= '0;
            outcnt_q      <= '0;
            src_restart_q <= 1'b1;
            win_ready_q   <= 1'b1;
          end
        end
        S_RUN: begin
          if (fire) begin
            if (col_q == OW_LAST) begin
              col_q <= '0;
              if (row_q == OH_LAST) begin
                row_q       <= '0;
                state_q     <= S_DRAIN;
                win_ready_q <= 1'b0;
                tmr_q       <= TMR_LOAD;
              end else begin
                row_q <= row_q + 8'd1;
              end
            end else begin
              col_q <= col_q + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (drained) begin
            state_q    <= S_MAPDN;
            map_done_q <= 1'b1;
          end else if (tmr_q == 8'd0) begin
            state_q    <= S_MAPDN;
            map_done_q <= 1'b1;
            err_q      <= 1'b1;
          end else begin
            tmr_q <= tmr_q - 8'd1;
          end
        end
        S_MAPDN: begin
          outcnt_q <= '0;
          row_q    <= '0;
          col_q    <= '0;
          if (phase_q == PH_LAST) begin
            state_q <= S_DONE;
            done_q  <= 1'b1;
          end else begin
            phase_q       <= phase_q + 2'd1;
            src_restart_q <= 1'b1;
            win_ready_q   <= 1'b1;
            state_q       <= S_RUN;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
          phase_q <= '0;
        end
        default: begin
          state_q     <= S_IDLE;
          win_ready_q <= 1'b0;
        end
      endcase
    end
  end

  assign oWinReady   = win_ready_q;
  assign oSrcRestart = src_restart_q;
  assign oInValid    = fire;
  assign oMapDone    = map_done_q;
  assign oPhase      = phase_q;
  assign oRow        = row_q;
  assign oCol        = col_q;
  assign oBusy       = (state_q != S_IDLE);
  assign oDone       = done_q;
  assign oErr        = err_q;

endmodule

// File: tb/tb_conv3x3_phase_sched.sv
// Scoreboard bench for conv3x3_phase_sched: the bench acts as window source and as a
// latency-3 wrapper stub; accepted windows are checked against a raster list per phase.
module tb_conv3x3_phase_sched;

  localparam int OW = 26, OH = 26, NWIN = OW * OH, NPHASE = 4, DRAIN_MAX = 16, LAT = 3;

  logic       iClk = 1'b0, iRsn = 1'b0, iStart = 1'b0, iWinValid = 1'b0;
  logic [3:0] iValid4 = 4'h0;
  logic       oWinReady, oSrcRestart, oInValid, oMapDone, oBusy, oDone, oErr;
  logic [1:0] oPhase;
  logic [7:0] oRow, oCol;

  conv3x3_phase_sched #(.IMG_W(28), .IMG_H(28), .NPHASE(NPHASE), .DRAIN_MAX(DRAIN_MAX)) dut (
    .iClk(iClk), .iRsn(iRsn), .iStart(iStart), .iWinValid(iWinValid),
    .oWinReady(oWinReady), .oSrcRestart(oSrcRestart), .oInValid(oInValid),
    .oMapDone(oMapDone), .iValid4(iValid4), .oPhase(oPhase), .oRow(oRow), .oCol(oCol),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  int tests = 0, fails = 0;
  logic [17:0] exp_q[$];
  int ph_q[$], run_q[$], drain_q[$], fq[$];
  int fire_cnt = 0, mapdone_cnt = 0, done_cnt = 0, restart_cnt = 0;
  int run_len = 0, drain_len = 0, fire_len = 0;
  logic prev_inv = 1'b0, last_fire = 1'b0;
  logic [LAT-1:0] pipe = '0;
  int   win_mode = 0;       // 0: no windows, 1: always valid, 2: 50% random
  logic suppress_last = 1'b0, inject_bad = 1'b0;
  int   stub_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // window source and wrapper stub
  always begin
    @(posedge iClk);
    #1;
    if (oMapDone || !iRsn) stub_cnt = 0;
    case (win_mode)
      1:       iWinValid = 1'b1;
      2:       iWinValid = 1'($urandom_range(0, 1));
      default: iWinValid = 1'b0;
    endcase
    if (inject_bad) begin
      iValid4 = 4'b0011;
      inject_bad = 1'b0;
    end else if (pipe[LAT-1]) begin
      if (suppress_last && stub_cnt == NWIN - 1) iValid4 = 4'h0;
      else begin
        iValid4 = 4'hF;
        stub_cnt++;
      end
    end else begin
      iValid4 = 4'h0;
    end
  end

  // monitor
  always @(negedge iClk) begin
    if (!iRsn) begin
      pipe = '0; last_fire = 1'b0; prev_inv = 1'b0;
      run_len = 0; drain_len = 0; fire_len = 0;
    end else begin
      if (last_fire) chk("ready_after_last_window", 32'(oWinReady), 32'd0);
      last_fire = oInValid && oRow == 8'(OH - 1) && oCol == 8'(OW - 1);
      if (oInValid) begin
        fire_cnt++; fire_len++;
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_fire: got %0h expected none", {oPhase, oRow, oCol});
        end else begin
          chk("fire_phase_row_col", 32'({oPhase, oRow, oCol}), 32'(exp_q.pop_front()));
        end
      end
      if (oWinReady) run_len++;
      if (oBusy && !oWinReady && !oMapDone && !oDone) drain_len++;
      if (oSrcRestart) restart_cnt++;
      if (oMapDone) begin
        chk("invalid_near_mapdone", 32'({prev_inv, oInValid}), 32'd0);
        mapdone_cnt++;
        ph_q.push_back(int'(oPhase));
        run_q.push_back(run_len); drain_q.push_back(drain_len); fq.push_back(fire_len);
        run_len = 0; drain_len = 0; fire_len = 0;
      end
      if (oDone) done_cnt++;
      prev_inv = oInValid;
      pipe = {pipe[LAT-2:0], oInValid};
    end
  end

  task automatic start_layer();
    for (int p = 0; p < NPHASE; p++)
      for (int r = 0; r < OH; r++)
        for (int c = 0; c < OW; c++)
          exp_q.push_back({2'(p), 8'(r), 8'(c)});
    @(posedge iClk); #2 iStart = 1'b1;
    @(posedge iClk); #2 iStart = 1'b0;
    chk("restart_on_start", 32'(oSrcRestart), 32'd1);
    chk("phase_on_start", 32'(oPhase), 32'd0);
    chk("err_cleared_on_start", 32'(oErr), 32'd0);
  endtask

  task automatic wait_done(input int budget);
    int base = done_cnt;
    int n = 0;
    while (done_cnt == base && n < budget) begin
      @(negedge iClk);
      n++;
    end
    chk("done_within_budget", 32'(done_cnt != base), 32'd1);
    @(negedge iClk);
  endtask

  task automatic clear_logs();
    ph_q.delete(); run_q.delete(); drain_q.delete(); fq.delete();
  endtask

  task automatic check_phases(input string tag, input int exp_drain);
    chk({tag, "_mapdone_entries"}, 32'(ph_q.size()), 32'(NPHASE));
    for (int i = 0; i < ph_q.size() && i < NPHASE; i++) begin
      chk({tag, "_phase_step"}, 32'(ph_q[i]), 32'(i));
      chk({tag, "_run_cycles"}, 32'(run_q[i]), 32'(NWIN));
      chk({tag, "_drain_cycles"}, 32'(drain_q[i]), 32'(exp_drain));
      chk({tag, "_fires_per_phase"}, 32'(fq[i]), 32'(NWIN));
    end
  endtask

  int b_fire, b_map, b_done, b_rst, n;
  logic [17:0] snap;
  logic found;

  initial begin
    // reset state
    repeat (3) @(negedge iClk);
    chk("rst_ready", 32'(oWinReady), 0);   chk("rst_restart", 32'(oSrcRestart), 0);
    chk("rst_invalid", 32'(oInValid), 0);  chk("rst_mapdone", 32'(oMapDone), 0);
    chk("rst_prc", 32'({oPhase, oRow, oCol}), 0);
    chk("rst_busy", 32'(oBusy), 0); chk("rst_done", 32'(oDone), 0); chk("rst_err", 32'(oErr), 0);
    iRsn = 1'b1;
    repeat (2) @(negedge iClk);

    // T1 ideal source, latency-3 wrapper
    clear_logs();
    b_fire = fire_cnt; b_map = mapdone_cnt; b_done = done_cnt; b_rst = restart_cnt;
    win_mode = 1;
    start_layer();
    wait_done(4 * (NWIN + 40));
    chk("t1_fires", 32'(fire_cnt - b_fire), 32'(NPHASE * NWIN));
    chk("t1_mapdones", 32'(mapdone_cnt - b_map), 32'(NPHASE));
    chk("t1_dones", 32'(done_cnt - b_done), 32'd1);
    chk("t1_restarts", 32'(restart_cnt - b_rst), 32'(NPHASE));
    chk("t1_busy_after", 32'(oBusy), 32'd0);
    chk("t1_err", 32'(oErr), 32'd0);
    check_phases("t1", LAT);

    // T2 random 50% source
    clear_logs();
    b_fire = fire_cnt; b_map = mapdone_cnt; b_done = done_cnt;
    win_mode = 2;
    start_layer();
    wait_done(4 * (4 * NWIN + 200));
    chk("t2_fires", 32'(fire_cnt - b_fire), 32'(NPHASE * NWIN));
    chk("t2_mapdones", 32'(mapdone_cnt - b_map), 32'(NPHASE));
    chk("t2_queue_empty", 32'(exp_q.size()), 32'd0);
    chk("t2_err", 32'(oErr), 32'd0);

    // T4 wrapper drops the last output of every phase
    clear_logs();
    b_map = mapdone_cnt;
    win_mode = 1; suppress_last = 1'b1;
    start_layer();
    wait_done(4 * (NWIN + 60));
    suppress_last = 1'b0;
    chk("t4_err", 32'(oErr), 32'd1);
    chk("t4_mapdones", 32'(mapdone_cnt - b_map), 32'(NPHASE));
    check_phases("t4", DRAIN_MAX);

    // T5 iStart mid-RUN ignored; bad iValid4 pattern sticks
    b_done = done_cnt;
    win_mode = 2;
    start_layer();
    repeat (200) @(negedge iClk);
    win_mode = 0;
    repeat (6) @(negedge iClk);
    snap = {oPhase, oRow, oCol}; b_rst = restart_cnt;
    @(posedge iClk); #2 iStart = 1'b1;
    @(posedge iClk); #2 iStart = 1'b0;
    repeat (2) @(negedge iClk);
    chk("t5_counters_kept", 32'({oPhase, oRow, oCol}), 32'(snap));
    chk("t5_no_restart", 32'(restart_cnt - b_rst), 32'd0);
    chk("t5_still_run", 32'(oWinReady), 32'd1);
    chk("t5_no_err_from_start", 32'(oErr), 32'd0);
    inject_bad = 1'b1;
    repeat (2) @(negedge iClk);
    chk("t5_err_set", 32'(oErr), 32'd1);
    win_mode = 2;
    wait_done(4 * (4 * NWIN + 200));
    chk("t5_err_sticky", 32'(oErr), 32'd1);
    chk("t5_queue_empty", 32'(exp_q.size()), 32'd0);
    repeat (6) @(negedge iClk);

    // T6 async reset at phase 2, window (10,5)
    b_map = mapdone_cnt;
    win_mode = 1;
    start_layer();
    found = 1'b0; n = 0;
    while (!found && n < 4 * (NWIN + 40)) begin
      @(negedge iClk);
      n++;
      found = oInValid && oPhase == 2'd2 && oRow == 8'd10 && oCol == 8'd5;
    end
    chk("t6_reached_2_10_5", 32'(found), 32'd1);
    #1 iRsn = 1'b0;
    #1;
    chk("t6_rst_ready", 32'(oWinReady), 0); chk("t6_rst_invalid", 32'(oInValid), 0);
    chk("t6_rst_prc", 32'({oPhase, oRow, oCol}), 0); chk("t6_rst_busy", 32'(oBusy), 0);
    chk("t6_rst_pulses", 32'({oSrcRestart, oMapDone, oDone, oErr}), 0);
    repeat (3) @(negedge iClk);
    chk("t6_mapdones_before_abort", 32'(mapdone_cnt - b_map), 32'd2);
    exp_q.delete();
    iRsn = 1'b1;
    repeat (2) @(negedge iClk);
    b_map = mapdone_cnt; b_done = done_cnt; b_fire = fire_cnt;
    start_layer();
    wait_done(4 * (NWIN + 40));
    chk("t6_rerun_fires", 32'(fire_cnt - b_fire), 32'(NPHASE * NWIN));
    chk("t6_rerun_mapdones", 32'(mapdone_cnt - b_map), 32'(NPHASE));
    chk("t6_rerun_done", 32'(done_cnt - b_done), 32'd1);
    chk("t6_queue_empty", 32'(exp_q.size()), 32'd0);

    win_mode = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
